// File: rtl/sp_result_writeback_pkg.sv
// Shared definitions for the result writeback path and the scratchpad.
// Element j = r*MAX_DIM+c lives at bits [(j+1)*BW-1 -: BW], LSB-first.
package sp_result_writeback_pkg;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_DONE  = 2'd2
    } wb_state_e;

    localparam int WB_DW      = 8;
    localparam int WB_BW      = 32;
    localparam int WB_MAX_DIM = WB_BW / WB_DW;
    localparam int WB_ADDR_W  = 4;

    function automatic int elem_idx(
        input int r,
        input int c,
        input int max_dim
    );
        return r * max_dim + c;
    endfunction

endpackage

// File: rtl/sp_result_writeback_rc_counter.sv
// Row/column walker over the active n x n block.
// Column wraps at n-1 and bumps the row; last_o flags (n-1,n-1).
module wb_rc_counter #(
    parameter int DIM_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] dim_i,
    output logic [DIM_W-1:0] row_o,
    output logic [DIM_W-1:0] col_o,
    output logic             last_o
);

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] lim;

    assign lim    = dim_i - DIM_W'(1);
    assign last_o = (row_q == lim) && (col_q == lim);
    assign row_o  = row_q;
    assign col_o  = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == lim) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/sp_result_writeback.sv
// Captures a result matrix on start and streams the active n x n block
// into one scratchpad section, one element per unstalled cycle.
module sp_result_writeback
    import sp_result_writeback_pkg::*;
#(
    parameter int DW       = WB_DW,
    parameter int BW       = WB_BW,
    parameter int MAX_DIM  = BW / DW,
    parameter int SPN      = 1,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int ELEM_NUM = MAX_DIM * MAX_DIM,
    parameter int DIM_W    = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [BW*ELEM_NUM-1:0] res_mat_i,
    input  logic                   start_i,
    input  logic [1:0]             sec_i,
    input  logic [DIM_W-1:0]       dim_i,
    input  logic                   stall_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ADDR_W-1:0]      sp_addr_o,
    output logic [BW-1:0]          sp_data_o,
    output logic                   sp_ena_o,
    output logic [1:0]             sp_sel_o
);

    wb_state_e              state_q;
    logic [BW*ELEM_NUM-1:0] mat_q;
    logic [1:0]             sec_q;
    logic [DIM_W-1:0]       dim_q;
    logic                   busy_q, done_q, err_q, ena_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [BW-1:0]          data_q;
    logic [1:0]             sel_q;

    logic                   start_bad, start_ok;
    logic                   cnt_en, cnt_last;
    logic [DIM_W-1:0]       row, col;
    logic [ADDR_W-1:0]      idx;
    logic [BW-1:0]          data_sel;

    assign start_bad = (dim_i == '0)
                     || (dim_i > DIM_W'(MAX_DIM))
                     || ({1'b0, sec_i} >= 3'(SPN));
    assign start_ok  = (state_q == WB_IDLE) && start_i && !start_bad;
    assign cnt_en    = (state_q == WB_WRITE) && !stall_i;

    // Address stride is MAX_DIM, not n, to match the scratchpad layout.
    assign idx      = ADDR_W'(elem_idx(int'(row), int'(col), MAX_DIM));
    assign data_sel = mat_q[int'(idx)*BW +: BW];

    wb_rc_counter #(
        .DIM_W (DIM_W)
    ) u_rc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start_ok),
        .en_i    (cnt_en),
        .dim_i   (dim_q),
        .row_o   (row),
        .col_o   (col),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= WB_IDLE;
            mat_q   <= '0;
            sec_q   <= '0;
            dim_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ena_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                WB_IDLE: begin
                    ena_q <= 1'b0;
                    if (start_i && start_bad) begin
                        err_q <= 1'b1;
                    end else if (start_ok) begin
                        mat_q   <= res_mat_i;
                        sec_q   <= sec_i;
                        dim_q   <= dim_i;
                        busy_q  <= 1'b1;
                        state_q <= WB_WRITE;
                    end
                end
                WB_WRITE: begin
                    if (!stall_i) begin
                        ena_q  <= 1'b1;
                        addr_q <= idx;
                        data_q <= data_sel;
                        sel_q  <= sec_q;
                        if (cnt_last) begin
                            state_q <= WB_DONE;
                        end
                    end else begin
                        ena_q <= 1'b0;
                    end
                end
                WB_DONE: begin
                    ena_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= WB_IDLE;
                end
                default: begin
                    ena_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= WB_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign sp_addr_o = addr_q;
    assign sp_data_o = data_q;
    assign sp_ena_o  = ena_q;
    assign sp_sel_o  = sel_q;

endmodule

// File: tb/tb_sp_result_writeback.sv
// Directed and randomized checks of the result writeback block
// against a row-major write-list model of the n x n block.
module tb_sp_result_writeback;

    localparam int BW   = 32;
    localparam int MD   = 4;
    localparam int NE   = MD * MD;
    localparam int AW   = 4;
    localparam int DIMW = 3;

    logic              clk;
    logic              reset_i;
    logic [BW*NE-1:0]  res_mat_i;
    logic              start_i;
    logic [1:0]        sec_i;
    logic [DIMW-1:0]   dim_i;
    logic              stall_i;
    logic              busy_o, done_o, err_o, sp_ena_o;
    logic [AW-1:0]     sp_addr_o;
    logic [BW-1:0]     sp_data_o;
    logic [1:0]        sp_sel_o;

    int errors = 0;
    int checks = 0;

    sp_result_writeback #(
        .DW       (8),
        .BW       (BW),
        .MAX_DIM  (MD),
        .SPN      (1),
        .ADDR_W   (AW),
        .ELEM_NUM (NE),
        .DIM_W    (DIMW)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .res_mat_i (res_mat_i),
        .start_i   (start_i),
        .sec_i     (sec_i),
        .dim_i     (dim_i),
        .stall_i   (stall_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .sp_addr_o (sp_addr_o),
        .sp_data_o (sp_data_o),
        .sp_ena_o  (sp_ena_o),
        .sp_sel_o  (sp_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ena"},  sp_ena_o,  0);
        chk({tag, "_busy"}, busy_o,    0);
        chk({tag, "_done"}, done_o,    0);
        chk({tag, "_err"},  err_o,     0);
        chk({tag, "_addr"}, sp_addr_o, 0);
        chk({tag, "_data"}, sp_data_o, 0);
        chk({tag, "_sel"},  sp_sel_o,  0);
    endtask

    // One full transfer; expected writes are the row-major n x n block.
    task automatic xfer(input int n, input int sec, input bit rnd,
                        input int pct, input int st_at,
                        input bit corrupt, input bit poke);
        logic [BW-1:0] m [NE];
        int            exp_a[$];
        logic [BW-1:0] exp_d[$];
        int            wr, st_cnt, cyc, last_a;
        bit            stall, have_last;
        for (int j = 0; j < NE; j++) begin
            m[j] = rnd ? BW'($urandom) : BW'(32'h100 + j);
            res_mat_i[j*BW +: BW] = m[j];
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                exp_a.push_back(r * MD + c);
                exp_d.push_back(m[r * MD + c]);
            end
        @(negedge clk);
        start_i = 1'b1;
        dim_i   = DIMW'(n);
        sec_i   = 2'(sec);
        stall_i = 1'b0;
        @(posedge clk); #1;
        chk("start_busy", busy_o,   1);
        chk("start_ena",  sp_ena_o, 0);
        chk("start_err",  err_o,    0);
        @(negedge clk);
        start_i = 1'b0;
        if (corrupt) begin
            res_mat_i = '1;
            dim_i     = 3'd1;
        end
        wr = 0; st_cnt = 0; cyc = 0; have_last = 0; last_a = 0;
        while (1) begin
            stall = 1'b0;
            if (exp_a.size() > 0) begin
                if ($urandom_range(99) < pct) stall = 1'b1;
                if (wr == st_at && st_cnt < 3) begin
                    stall = 1'b1;
                    st_cnt++;
                end
            end
            stall_i = stall;
            start_i = poke && (cyc == 3);
            @(posedge clk); #1;
            if (exp_a.size() > 0) begin
                chk("wr_ena",  sp_ena_o, !stall);
                chk("wr_busy", busy_o,   1);
                chk("wr_done", done_o,   0);
                chk("wr_err",  err_o,    0);
                if (!stall) begin
                    last_a = exp_a.pop_front();
                    chk("wr_addr", sp_addr_o, last_a);
                    chk("wr_data", sp_data_o, exp_d.pop_front());
                    chk("wr_sel",  sp_sel_o,  sec);
                    have_last = 1;
                    wr++;
                end else if (have_last) begin
                    chk("stall_addr_hold", sp_addr_o, last_a);
                end
            end else begin
                chk("end_done", done_o,   1);
                chk("end_busy", busy_o,   0);
                chk("end_ena",  sp_ena_o, 0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        stall_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", done_o,   0);
        chk("post_ena",   sp_ena_o, 0);
    endtask

    task automatic reject(input int n, input int sec, input string tag);
        @(negedge clk);
        start_i = 1'b1;
        dim_i   = DIMW'(n);
        sec_i   = 2'(sec);
        @(posedge clk); #1;
        chk({tag, "_err"},  err_o,    1);
        chk({tag, "_busy"}, busy_o,   0);
        chk({tag, "_ena"},  sp_ena_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_err_clr"}, err_o,    0);
        chk({tag, "_ena2"},    sp_ena_o, 0);
        chk({tag, "_busy2"},   busy_o,   0);
    endtask

    initial begin
        int wr;
        reset_i   = 1'b1;
        res_mat_i = '0;
        start_i   = 1'b0;
        sec_i     = '0;
        dim_i     = '0;
        stall_i   = 1'b0;
        #2;
        chk_idle_outs("reset");
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk); #1;
        chk_idle_outs("post_reset");

        xfer(4, 0, 0, 0, -1, 0, 0);
        xfer(2, 0, 0, 0, -1, 0, 0);
        xfer(4, 0, 0, 0, 5, 0, 0);

        reject(4, 1, "rej_sec");
        reject(0, 0, "rej_dim0");
        reject(5, 0, "rej_dim5");

        xfer(4, 0, 0, 0, -1, 1, 1);

        for (int k = 0; k < 8; k++)
            xfer($urandom_range(1, 4), 0, 1, 30, -1, k[0], k[1]);

        // Abort mid-transfer with an asynchronous reset.
        for (int j = 0; j < NE; j++) res_mat_i[j*BW +: BW] = BW'(32'h100 + j);
        @(negedge clk);
        start_i = 1'b1;
        dim_i   = 3'd4;
        sec_i   = 2'd0;
        @(negedge clk);
        start_i = 1'b0;
        wr = 0;
        for (int k = 0; k < 40 && wr < 7; k++) begin
            @(posedge clk); #1;
            if (sp_ena_o) wr++;
        end
        chk("abort_reach7", wr, 7);
        #2;
        reset_i = 1'b1;
        #1;
        chk_idle_outs("abort");
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_nodone", done_o, 0);
            chk("abort_noena",  sp_ena_o, 0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        xfer(4, 0, 0, 0, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
